mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (instruction fetch / data) front end for a single-port
// synchronous RAM.
//
// Data requests win a conflict unless the instruction port has already been
// denied STARVE_MAX consecutive cycles, in which case instruction wins. Grants
// are combinational and drive the RAM in the grant cycle. The RAM returns read
// data one cycle later, so the owner of each read is registered and used to
// steer m_rdata back to the requester that issued it.
//
// Ports
//   clk, reset           clock; asynchronous active-high reset
//   i_req, i_addr        fetch request / address
//   i_gnt                fetch accepted this cycle
//   i_rvalid, i_rdata    fetch data, one cycle after i_gnt
//   d_req, d_we,         data request, write enable, address, write data
//   d_addr, d_wdata
//   d_gnt                data access accepted this cycle
//   d_rvalid, d_rdata    load data, one cycle after a load grant
//   m_en, m_we, m_addr,  RAM command (valid in the grant cycle)
//   m_wdata
//   m_rdata              RAM read data, valid the cycle after a read command
//
// Read-owner states
//   state      | meaning
//   OWN_NONE   | no read issued last cycle; both rvalids low
//   OWN_INSTR  | last cycle issued a fetch; m_rdata belongs to the fetch port
//   OWN_DREAD  | last cycle issued a load; m_rdata belongs to the data port

module mem_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 3
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [DW-1:0] i_rdata,

    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,

    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_INSTR = 2'd1,
        OWN_DREAD = 2'd2
    } owner_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] starve_cnt_q, starve_cnt_d;
    owner_t     owner_q, owner_d;
    logic       i_win;

    // Grant decision and RAM command mux.
    always_comb begin
        i_gnt   = 1'b0;
        d_gnt   = 1'b0;
        m_en    = 1'b0;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;

        // Instruction wins when alone, or when it has waited long enough.
        i_win = i_req && (!d_req || (starve_cnt_q == STARVE_LIM));

        if (!reset) begin
            i_gnt = i_win;
            d_gnt = d_req && !i_win;
        end

        if (i_gnt) begin
            m_en   = 1'b1;
            m_addr = i_addr;
        end else if (d_gnt) begin
            m_en    = 1'b1;
            m_we    = d_we;
            m_addr  = d_addr;
            m_wdata = d_wdata;
        end
    end

    // Next-state for the starvation counter and read owner.
    always_comb begin
        starve_cnt_d = 4'd0;
        owner_d      = OWN_NONE;

        if (i_req && !i_gnt) begin
            if (starve_cnt_q < STARVE_LIM) begin
                starve_cnt_d = starve_cnt_q + 4'd1;
            end else begin
                starve_cnt_d = STARVE_LIM;
            end
        end

        if (i_gnt) begin
            owner_d = OWN_INSTR;
        end else if (d_gnt && !d_we) begin
            owner_d = OWN_DREAD;
        end
    end

    // Async reset clears the owner, so a read in flight is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt_q <= 4'd0;
            owner_q      <= OWN_NONE;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            owner_q      <= owner_d;
        end
    end

    assign i_rvalid = (owner_q == OWN_INSTR);
    assign d_rvalid = (owner_q == OWN_DREAD);
    assign i_rdata  = i_rvalid ? m_rdata : '0;
    assign d_rdata  = d_rvalid ? m_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SM = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic          i_gnt, i_rvalid;
    logic [DW-1:0] i_rdata;
    logic          d_req, d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt, d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          m_en, m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SM)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural single-port synchronous RAM seen by the DUT.
    logic [31:0] ram [logic [31:0]];
    always @(posedge clk) begin
        if (m_en) begin
            if (m_we) ram[m_addr] = m_wdata;
            else      m_rdata <= ram.exists(m_addr) ? ram[m_addr] : 32'h0;
        end
    end

    // Reference model: expected memory contents, current-cycle grant
    // decision, outstanding read expected this cycle, and the length of the
    // current run of cycles in which the fetch port was refused.
    logic [31:0] ref_mem [logic [31:0]];
    logic        exp_ig, exp_dg;
    logic        pend_iv, pend_dv;
    logic [31:0] pend_data;
    int          denied_run;

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    function automatic logic [3:0] exp_starve();
        return (denied_run > SM) ? 4'(SM) : 4'(denied_run);
    endfunction

    // Drive one cycle of inputs at the falling edge and predict the grant.
    task automatic cycle(input logic ir, input logic [31:0] ia,
                         input logic dr, input logic dwe,
                         input logic [31:0] da, input logic [31:0] dd);
        @(negedge clk);
        reset   = 1'b0;
        i_req   = ir;  i_addr  = ia;
        d_req   = dr;  d_we    = dwe;
        d_addr  = da;  d_wdata = dd;
        #1;
        exp_ig = i_req && (!d_req || denied_run >= SM);
        exp_dg = d_req && !exp_ig;
    endtask

    task automatic idle();
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    // Clock edge: commit the predicted cycle into the model.
    task automatic advance();
        @(posedge clk);
        pend_iv = 1'b0;
        pend_dv = 1'b0;
        if (exp_ig) begin
            pend_iv   = 1'b1;
            pend_data = ref_rd(i_addr);
        end else if (exp_dg && !d_we) begin
            pend_dv   = 1'b1;
            pend_data = ref_rd(d_addr);
        end
        if (exp_dg && d_we) ref_mem[d_addr] = d_wdata;
        denied_run = (i_req && !exp_ig) ? denied_run + 1 : 0;
    endtask

    task automatic model_reset();
        pend_iv = 1'b0; pend_dv = 1'b0; denied_run = 0;
        exp_ig = 1'b0;  exp_dg = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        i_req = 1'b1; i_addr = 32'h100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000; d_wdata = 32'h0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if ({i_gnt, d_gnt, m_en} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_grants: got %b want 000", {i_gnt, d_gnt, m_en});
        end
        n_tests++;
        if ({i_rvalid, d_rvalid, i_rdata, d_rdata} !== 66'h0) begin
            n_fail++;
            $display("FAIL reset_read: iv=%b dv=%b ird=%h drd=%h want all 0",
                     i_rvalid, d_rvalid, i_rdata, d_rdata);
        end
        n_tests++;
        if (dut.starve_cnt_q !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_starve: got %0d want 0", dut.starve_cnt_q);
        end
    endtask

    task automatic test_single_fetch();
        cycle(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0);
        n_tests++;
        if ({i_gnt, d_gnt, m_en, m_we, m_addr, m_wdata} !== {4'b1010, 32'h100, 32'h0}) begin
            n_fail++;
            $display("FAIL fetch_grant: ig=%b dg=%b en=%b we=%b addr=%h wd=%h want 1 0 1 0 100 0",
                     i_gnt, d_gnt, m_en, m_we, m_addr, m_wdata);
        end
        advance();
        idle();
        n_tests++;
        if ({i_rvalid, i_rdata, d_rvalid} !== {1'b1, 32'h00500093, 1'b0}) begin
            n_fail++;
            $display("FAIL fetch_data: iv=%b ird=%h dv=%b want 1 00500093 0",
                     i_rvalid, i_rdata, d_rvalid);
        end
        advance();
    endtask

    task automatic test_conflict();
        cycle(1'b1, 32'h300, 1'b1, 1'b0, 32'h2000, 32'h0);
        n_tests++;
        if ({i_gnt, d_gnt, m_en, m_we, m_addr} !== {4'b0110, 32'h2000}) begin
            n_fail++;
            $display("FAIL conflict_grant: ig=%b dg=%b en=%b we=%b addr=%h want 0 1 1 0 2000",
                     i_gnt, d_gnt, m_en, m_we, m_addr);
        end
        advance();
        cycle(1'b1, 32'h300, 1'b0, 1'b0, 32'h0, 32'h0);
        n_tests++;
        if ({d_rvalid, d_rdata, i_rvalid, i_gnt} !== {1'b1, 32'hCAFE0001, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL conflict_data: dv=%b drd=%h iv=%b ig=%b want 1 cafe0001 0 1",
                     d_rvalid, d_rdata, i_rvalid, i_gnt);
        end
        advance();
        idle();
        advance();
    endtask

    task automatic test_starvation();
        logic [4:0] want_i;
        logic [3:0] want_cnt [5];
        want_i = 5'b01000;
        want_cnt = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
        for (int c = 0; c < 5; c++) begin
            cycle(1'b1, 32'h100, 1'b1, 1'b0, 32'h2000, 32'h0);
            n_tests++;
            if ({i_gnt, d_gnt, dut.starve_cnt_q} !== {want_i[c], !want_i[c], want_cnt[c]}) begin
                n_fail++;
                $display("FAIL starve_c%0d: ig=%b dg=%b cnt=%0d want %b %b %0d", c,
                         i_gnt, d_gnt, dut.starve_cnt_q, want_i[c], !want_i[c], want_cnt[c]);
            end
            advance();
        end
        idle();
        advance();
    endtask

    task automatic test_store();
        cycle(1'b0, 32'h0, 1'b1, 1'b1, 32'h40, 32'hDEADBEEF);
        n_tests++;
        if ({d_gnt, m_en, m_we, m_addr, m_wdata} !== {3'b111, 32'h40, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL store_cmd: dg=%b en=%b we=%b addr=%h wd=%h want 1 1 1 40 deadbeef",
                     d_gnt, m_en, m_we, m_addr, m_wdata);
        end
        advance();
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0);
        n_tests++;
        if ({d_rvalid, d_gnt} !== 2'b01) begin
            n_fail++;
            $display("FAIL store_no_rvalid: dv=%b dg=%b want 0 1", d_rvalid, d_gnt);
        end
        advance();
        idle();
        n_tests++;
        if ({d_rvalid, d_rdata} !== {1'b1, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL store_readback: dv=%b drd=%h want 1 deadbeef", d_rvalid, d_rdata);
        end
        advance();
    endtask

    task automatic test_back_to_back();
        cycle(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0);
        advance();
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0);
        n_tests++;
        if ({i_rvalid, i_rdata, d_gnt, d_rvalid} !== {1'b1, 32'h00500093, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_fetch: iv=%b ird=%h dg=%b dv=%b want 1 00500093 1 0",
                     i_rvalid, i_rdata, d_gnt, d_rvalid);
        end
        advance();
        idle();
        n_tests++;
        if ({d_rvalid, d_rdata, i_rvalid, i_rdata} !== {1'b1, 32'hDEADBEEF, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL b2b_load: dv=%b drd=%h iv=%b ird=%h want 1 deadbeef 0 0",
                     d_rvalid, d_rdata, i_rvalid, i_rdata);
        end
        advance();
    endtask

    task automatic test_reset_mid_read();
        // Pulse lands inside the grant cycle, before the capturing edge.
        cycle(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0);
        #2 reset = 1'b1;
        #1;
        n_tests++;
        if ({i_gnt, d_gnt, m_en} !== 3'b000) begin
            n_fail++;
            $display("FAIL midreset_grant: got %b want 000", {i_gnt, d_gnt, m_en});
        end
        #1 reset = 1'b0;
        i_req = 1'b0;
        model_reset();
        advance();
        idle();
        n_tests++;
        if ({i_rvalid, i_rdata} !== 33'h0) begin
            n_fail++;
            $display("FAIL midreset_a_rvalid: iv=%b ird=%h want 0 0", i_rvalid, i_rdata);
        end
        advance();

        // Pulse lands after the capturing edge, while the read is in flight.
        cycle(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0);
        advance();
        #1 reset = 1'b1;
        i_req = 1'b0;
        #1;
        n_tests++;
        if (i_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_b_during: iv=%b want 0", i_rvalid);
        end
        #1 reset = 1'b0;
        model_reset();
        idle();
        n_tests++;
        if ({i_rvalid, i_rdata} !== 33'h0) begin
            n_fail++;
            $display("FAIL midreset_b_after: iv=%b ird=%h want 0 0", i_rvalid, i_rdata);
        end
        advance();

        cycle(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0);
        n_tests++;
        if (i_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL postreset_grant: ig=%b want 1", i_gnt);
        end
        advance();
        idle();
        n_tests++;
        if ({i_rvalid, i_rdata} !== {1'b1, 32'h00500093}) begin
            n_fail++;
            $display("FAIL postreset_data: iv=%b ird=%h want 1 00500093", i_rvalid, i_rdata);
        end
        advance();
    endtask

    task automatic test_random();
        logic        ir, dr, dwe;
        logic [31:0] ia, da, dd;
        logic [65:0] want_m;
        for (int c = 0; c < 400; c++) begin
            // A refused requester holds its request until it is granted.
            if (i_req && !exp_ig) begin
                ir = 1'b1; ia = i_addr;
            end else begin
                ir = ($urandom_range(0, 3) != 0);
                ia = {24'h0, 3'($urandom_range(0, 7)), 5'h0} | 32'h100;
            end
            if (d_req && !exp_dg) begin
                dr = 1'b1; dwe = d_we; da = d_addr; dd = d_wdata;
            end else begin
                dr  = ($urandom_range(0, 3) != 0);
                dwe = ($urandom_range(0, 2) == 0);
                da  = {24'h0, 3'($urandom_range(0, 7)), 5'h0} | 32'h100;
                dd  = $urandom;
            end
            cycle(ir, ia, dr, dwe, da, dd);

            if (exp_ig)      want_m = {2'b10, ia, 32'h0};
            else if (exp_dg) want_m = {1'b1, dwe, da, dd};
            else             want_m = '0;

            n_tests++;
            if ({i_gnt, d_gnt} !== {exp_ig, exp_dg}) begin
                n_fail++;
                $display("FAIL rnd_grant c%0d: ig=%b dg=%b want %b %b",
                         c, i_gnt, d_gnt, exp_ig, exp_dg);
            end
            n_tests++;
            if ({m_en, m_we, m_addr, m_wdata} !== want_m) begin
                n_fail++;
                $display("FAIL rnd_mem c%0d: got %h want %h",
                         c, {m_en, m_we, m_addr, m_wdata}, want_m);
            end
            n_tests++;
            if ({i_rvalid, i_rdata, d_rvalid, d_rdata} !==
                {pend_iv, pend_iv ? pend_data : 32'h0, pend_dv, pend_dv ? pend_data : 32'h0}) begin
                n_fail++;
                $display("FAIL rnd_read c%0d: iv=%b ird=%h dv=%b drd=%h want %b %b data %h",
                         c, i_rvalid, i_rdata, d_rvalid, d_rdata, pend_iv, pend_dv, pend_data);
            end
            n_tests++;
            if (dut.starve_cnt_q !== exp_starve()) begin
                n_fail++;
                $display("FAIL rnd_starve c%0d: got %0d want %0d",
                         c, dut.starve_cnt_q, exp_starve());
            end
            advance();
        end
    endtask

    initial begin
        m_rdata = 32'h0;
        ram[32'h100]      = 32'h00500093;
        ref_mem[32'h100]  = 32'h00500093;
        ram[32'h2000]     = 32'hCAFE0001;
        ref_mem[32'h2000] = 32'hCAFE0001;

        test_reset();
        test_single_fetch();
        test_conflict();
        test_starvation();
        test_store();
        test_back_to_back();
        test_reset_mid_read();
        test_random();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
